arg_store_scanner: RTL

ARG_STORE_SCANNER -- requirements
Module: arg_store_scanner

---
 rtl/arg_store_pkg.sv | 27 ++
 rtl/arg_row_mem.sv | 45 ++++
 rtl/arg_store_scanner.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/arg_store_pkg.sv
// -----------------------------------------------------------------------------
// arg_store_pkg
// Shared types for the argument store / column scanner:
//   - default-width row / column / data typedefs (arg_row_t, arg_col_t,
//     arg_data_t) matching the scanner's default parameters
//   - scan_state_t, the column-streaming FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package arg_store_pkg;

    localparam int ARG_ROW_WIDTH_DEF  = 3;
    localparam int ARG_COL_WIDTH_DEF  = 10;
    localparam int ARG_DATA_WIDTH_DEF = 16;

    typedef logic [ARG_ROW_WIDTH_DEF-1:0]  arg_row_t;
    typedef logic [ARG_COL_WIDTH_DEF-1:0]  arg_col_t;
    typedef logic [ARG_DATA_WIDTH_DEF-1:0] arg_data_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } scan_state_t;

endpackage

// File: rtl/arg_row_mem.sv
// -----------------------------------------------------------------------------
// arg_row_mem
// One row of argument storage: simple dual-port memory, one write port and one
// registered read port (1-cycle read latency). Contents are not reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write enable
//   wr_addr  in   write address (column)
//   wr_data  in   write data
//   rd_en    in   read enable; rd_data updates on the following edge
//   rd_addr  in   read address (column)
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module arg_row_mem
    import arg_store_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/arg_store_scanner.sv
// -----------------------------------------------------------------------------
// arg_store_scanner
// Stores argument words addressed by (row, column) and, on request, streams
// every column 0..max_col as one beat carrying all rows plus a row-presence
// mask. Writes are only accepted while idle; writes during a scan are dropped
// and flagged on the sticky wr_dropped output.
//
// Optional feature macro: ARG_STORE_SCANNER_CLEAR_ON_SCAN_EN
//   defined   -> the end of each scan clears presence, max_col and has_data
//   undefined -> stored state persists, repeated scans return identical beats
//
// Ports:
//   clk           in   clock
//   rst_n         in   synchronous active-low reset
//   wr_arg_valid  in   write strobe
//   wr_arg_row    in   target row
//   wr_arg_col    in   target column
//   wr_arg_data   in   argument value
//   scan_start    in   single-cycle scan request (honoured only when idle)
//   scan_busy     out  scan in progress
//   out_valid     out  column beat valid
//   out_ready     in   downstream accepts beat
//   out_col       out  column index of beat
//   out_data      out  all rows, row r at [r*ARG_DATA_WIDTH +: ARG_DATA_WIDTH]
//   out_row_mask  out  bit r set if row r was written for this column
//   out_last      out  final beat of scan
//   scan_done     out  one-cycle pulse at end of scan
//   wr_dropped    out  sticky: a write arrived while busy
// -----------------------------------------------------------------------------
module arg_store_scanner
    import arg_store_pkg::*;
#(
    parameter int ARG_ROW_WIDTH  = 3,
    parameter int ARG_COL_WIDTH  = 10,
    parameter int ARG_DATA_WIDTH = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     wr_arg_valid,
    input  logic [ARG_ROW_WIDTH-1:0]                 wr_arg_row,
    input  logic [ARG_COL_WIDTH-1:0]                 wr_arg_col,
    input  logic [ARG_DATA_WIDTH-1:0]                wr_arg_data,
    input  logic                                     scan_start,
    output logic                                     scan_busy,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [ARG_COL_WIDTH-1:0]                 out_col,
    output logic [(2**ARG_ROW_WIDTH)*ARG_DATA_WIDTH-1:0] out_data,
    output logic [(2**ARG_ROW_WIDTH)-1:0]            out_row_mask,
    output logic                                     out_last,
    output logic                                     scan_done,
    output logic                                     wr_dropped
);

    localparam int NUM_ROWS = 2 ** ARG_ROW_WIDTH;
    localparam int NUM_COLS = 2 ** ARG_COL_WIDTH;
    localparam logic [ARG_COL_WIDTH-1:0] COL_ONE = {{(ARG_COL_WIDTH-1){1'b0}}, 1'b1};

    scan_state_t state_reg, state_next;

    logic [ARG_COL_WIDTH-1:0]  col_reg;
    logic [ARG_COL_WIDTH-1:0]  max_col_reg;
    logic                      has_data_reg;
    logic [NUM_ROWS-1:0]       presence_reg [NUM_COLS];
    logic [ARG_DATA_WIDTH-1:0] rd_data      [NUM_ROWS];
    logic [ARG_DATA_WIDTH-1:0] out_data_reg [NUM_ROWS];
    logic [NUM_ROWS-1:0]       out_row_mask_reg;
    logic [ARG_COL_WIDTH-1:0]  out_col_reg;
    logic                      scan_done_reg;
    logic                      wr_dropped_reg;

    logic wr_accept;
    logic scan_accept;
    logic beat_taken;
    logic rd_en;
    logic clear_stored;

    assign wr_accept   = wr_arg_valid && (state_reg == ST_IDLE);
    assign scan_accept = scan_start && (state_reg == ST_IDLE);
    assign beat_taken  = (state_reg == ST_PRESENT) && out_ready;

`ifdef ARG_STORE_SCANNER_CLEAR_ON_SCAN_EN
    assign clear_stored = (state_reg == ST_DONE);
`else
    assign clear_stored = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        scan_busy  = 1'b1;
        out_valid  = 1'b0;
        rd_en      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                scan_busy = 1'b0;
                // A write in the same cycle counts as data for this scan.
                if (scan_start) begin
                    state_next = (has_data_reg || wr_accept) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                rd_en      = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = (col_reg < max_col_reg) ? ST_READ : ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- row memories
    generate
        for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
            arg_row_mem #(
                .ADDR_WIDTH(ARG_COL_WIDTH),
                .DATA_WIDTH(ARG_DATA_WIDTH)
            ) u_mem (
                .clk     (clk),
                .wr_en   (wr_accept && (wr_arg_row == ARG_ROW_WIDTH'(gi))),
                .wr_addr (wr_arg_col),
                .wr_data (wr_arg_data),
                .rd_en   (rd_en),
                .rd_addr (col_reg),
                .rd_data (rd_data[gi])
            );

            // Read data lands during WAIT; capture it into the beat register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_data_reg[gi] <= '0;
                end else if (state_reg == ST_WAIT) begin
                    out_data_reg[gi] <= rd_data[gi];
                end
            end

            assign out_data[gi*ARG_DATA_WIDTH +: ARG_DATA_WIDTH] = out_data_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------ presence bitmap
    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_pres
            always_ff @(posedge clk) begin
                if (!rst_n || clear_stored) begin
                    presence_reg[gi] <= '0;
                end else if (wr_accept && (wr_arg_col == ARG_COL_WIDTH'(gi))) begin
                    presence_reg[gi][wr_arg_row] <= 1'b1;
                end
            end
        end
    endgenerate

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_reg          <= '0;
            max_col_reg      <= '0;
            has_data_reg     <= 1'b0;
            out_row_mask_reg <= '0;
            out_col_reg      <= '0;
            scan_done_reg    <= 1'b0;
            wr_dropped_reg   <= 1'b0;
        end else begin
            // Registered pulse: high in the cycle after DONE.
            scan_done_reg <= (state_reg == ST_DONE);

            if (clear_stored) begin
                max_col_reg  <= '0;
                has_data_reg <= 1'b0;
            end else if (wr_accept) begin
                has_data_reg <= 1'b1;
                if (wr_arg_col > max_col_reg) begin
                    max_col_reg <= wr_arg_col;
                end
            end

            if (wr_arg_valid && (state_reg != ST_IDLE)) begin
                wr_dropped_reg <= 1'b1;
            end else if (scan_accept) begin
                wr_dropped_reg <= 1'b0;
            end

            if (scan_accept) begin
                col_reg <= '0;
            end else if (beat_taken && (col_reg < max_col_reg)) begin
                col_reg <= col_reg + COL_ONE;
            end

            if (state_reg == ST_WAIT) begin
                out_col_reg      <= col_reg;
                out_row_mask_reg <= presence_reg[col_reg];
            end
        end
    end

    assign out_col      = out_col_reg;
    assign out_row_mask = out_row_mask_reg;
    assign out_last     = (state_reg == ST_PRESENT) && (out_col_reg == max_col_reg);
    assign scan_done    = scan_done_reg;
    assign wr_dropped   = wr_dropped_reg;

endmodule
